// File: rtl/obi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : obi_pkg
//  Purpose  : OBI configuration and request/response channel types.
//  Revision : 1.0
// ============================================================================
package obi_pkg;

    typedef struct packed {
        int unsigned DataWidth;
        int unsigned AddrWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{DataWidth: 32, AddrWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [0:0]  aid;
        logic [31:0] wdata;
        logic        a_optional;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
        logic        r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        obi_r_chan_t r;
        logic        gnt;
        logic        rvalid;
    } obi_rsp_t;

endpackage
`default_nettype wire

// File: rtl/user_pulse_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : user_pulse_monitor
//  Purpose  : Measures pulse high time and period, buffers records in a FIFO
//             readable over an OBI subordinate port.
//  Revision : 1.0
// ============================================================================
module user_pulse_monitor #(
    parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
    parameter int unsigned       FifoDepth = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    input  logic     pulse_i,
    output logic     irq_o
);

    localparam int unsigned DW = ObiCfg.DataWidth;
    localparam int unsigned PW = $clog2(FifoDepth);

    localparam logic [7:0]  c_ADDR_CTRL   = 8'h00;
    localparam logic [7:0]  c_ADDR_STATUS = 8'h04;
    localparam logic [7:0]  c_ADDR_DATA   = 8'h08;
    localparam logic [7:0]  c_ADDR_PCOUNT = 8'h0C;
    localparam logic [15:0] c_SAT         = 16'hFFFF;
    localparam logic [PW:0] c_FULL        = FifoDepth[PW:0];

    logic        r_req, r_we;
    logic [0:0]  r_aid;
    logic [7:0]  r_addr;
    logic [2:0]  r_wdata;

    logic        r_en, r_pulse_q, r_armed, r_have_prev, r_ovf;
    logic [15:0] r_high, r_period, r_latched;
    logic [31:0] r_pcount;

    logic [31:0]   r_mem [FifoDepth];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_count;

    logic          w_rd, w_wr, w_ctrl_wr, w_stat_wr, w_clear;
    logic          w_empty, w_full, w_rise, w_fall;
    logic          w_push_evt, w_push, w_pop, w_drop;
    logic [3:0]    w_level;
    logic [DW-1:0] w_rdata;
    logic          w_unused_bits;

    assign w_unused_bits = ^{obi_req_i.a.addr[31:8], obi_req_i.a.wdata[31:3],
                             obi_req_i.a.be, obi_req_i.a.a_optional};

    // Register accesses act in the response cycle, using the captured request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_aid   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_req   <= obi_req_i.req;
            r_we    <= obi_req_i.a.we;
            r_aid   <= obi_req_i.a.aid;
            r_addr  <= obi_req_i.a.addr[7:0];
            r_wdata <= obi_req_i.a.wdata[2:0];
        end
    end

    assign w_rd      = r_req & ~r_we;
    assign w_wr      = r_req & r_we;
    assign w_ctrl_wr = w_wr && (r_addr == c_ADDR_CTRL);
    assign w_stat_wr = w_wr && (r_addr == c_ADDR_STATUS);
    assign w_clear   = w_ctrl_wr & r_wdata[1];

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_level = 4'(r_count);
    assign irq_o   = ~w_empty;

    assign w_rise = r_en & pulse_i & ~r_pulse_q;
    assign w_fall = r_en & ~pulse_i & r_pulse_q;

    assign w_push_evt = w_fall & r_armed & ~w_clear;
    assign w_pop      = w_rd && (r_addr == c_ADDR_DATA) && !w_empty;
    assign w_push     = w_push_evt & (~w_full | w_pop);
    assign w_drop     = w_push_evt & w_full & ~w_pop;

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (r_addr)
                c_ADDR_CTRL:   w_rdata = {31'b0, r_en};
                c_ADDR_STATUS: w_rdata = {24'b0, w_level, 1'b0, r_ovf, w_full, w_empty};
                c_ADDR_DATA:   w_rdata = w_empty ? 32'h0 : r_mem[r_rd_ptr];
                c_ADDR_PCOUNT: w_rdata = r_pcount;
                default:       w_rdata = 32'hDEADBEEF;
            endcase
        end
    end

    always_comb begin
        obi_rsp_o              = '0;
        obi_rsp_o.gnt          = obi_req_i.req;
        obi_rsp_o.rvalid       = r_req;
        obi_rsp_o.r.rdata      = w_rdata;
        obi_rsp_o.r.rid        = r_aid;
        obi_rsp_o.r.err        = 1'b0;
        obi_rsp_o.r.r_optional = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pulse_q <= 1'b0;
        end else begin
            r_pulse_q <= pulse_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_en        <= 1'b0;
            r_high      <= '0;
            r_period    <= '0;
            r_latched   <= '0;
            r_armed     <= 1'b0;
            r_have_prev <= 1'b0;
            r_ovf       <= 1'b0;
            r_pcount    <= '0;
        end else if (w_clear) begin
            r_en        <= r_wdata[0];
            r_high      <= '0;
            r_period    <= '0;
            r_latched   <= '0;
            r_armed     <= 1'b0;
            r_have_prev <= 1'b0;
            r_ovf       <= 1'b0;
            r_pcount    <= '0;
        end else begin
            if (w_rise) begin
                r_high      <= 16'd1;
                r_period    <= 16'd1;
                r_armed     <= 1'b1;
                r_latched   <= r_have_prev ? r_period : 16'd0;
                r_have_prev <= 1'b1;
            end else if (r_en) begin
                if (pulse_i && (r_high != c_SAT)) r_high <= r_high + 16'd1;
                if (r_period != c_SAT) r_period <= r_period + 16'd1;
            end
            // Dropped records still count as seen pulses.
            if (w_fall && r_armed) begin
                r_armed  <= 1'b0;
                r_pcount <= r_pcount + 32'd1;
            end
            if (w_stat_wr && r_wdata[2]) r_ovf <= 1'b0;
            if (w_drop) r_ovf <= 1'b1;
            if (w_ctrl_wr) begin
                r_en <= r_wdata[0];
                if (!r_wdata[0]) begin
                    r_armed     <= 1'b0;
                    r_have_prev <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // On a full push+pop the write slot is the head being read this cycle.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_latched, r_high};
    end

endmodule
`default_nettype wire

// File: tb/tb_user_pulse_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_user_pulse_monitor
//  Purpose  : Self-checking bench for user_pulse_monitor (scoreboarded OBI reads).
//  Revision : 1.0
// ============================================================================
module tb_user_pulse_monitor;
    import obi_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    obi_req_t req;
    obi_rsp_t rsp;
    logic     pulse;
    logic     irq;

    always #5 clk = ~clk;

    user_pulse_monitor #(
        .ObiCfg    (ObiDefaultConfig),
        .obi_req_t (obi_req_t),
        .obi_rsp_t (obi_rsp_t),
        .FifoDepth (4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .obi_req_i (req),
        .obi_rsp_o (rsp),
        .pulse_i   (pulse),
        .irq_o     (irq)
    );

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        rid;
        string       name;
    } exp_t;

    vec_t rv[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic aid_tog  = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus_issue(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                             input logic [31:0] exp, input string nm);
        exp_t e;
        req           = '0;
        req.req       = 1'b1;
        req.a.we      = we;
        req.a.addr    = {24'h0, addr};
        req.a.wdata   = wd;
        req.a.be      = 4'hF;
        req.a.aid     = aid_tog;
        e.rdata       = we ? 32'h0 : exp;
        e.rid         = aid_tog;
        e.name        = nm;
        sb.push_back(e);
        aid_tog       = ~aid_tog;
    endtask

    task automatic bus_idle();
        req = '0;
    endtask

    task automatic bus(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp, input string nm);
        bus_issue(we, addr, wd, exp, nm);
        tick();
        bus_idle();
    endtask

    task automatic pulse_n(input int hi, input int lo);
        pulse = 1'b1;
        repeat (hi) tick();
        pulse = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic apply_table();
        foreach (rv[i]) bus(rv[i].we, rv[i].addr, rv[i].wdata, rv[i].exp, rv[i].name);
        repeat (2) tick();
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_irq"},    32'(irq),         32'h0);
        check({tag, "_rvalid"}, 32'(rsp.rvalid),  32'h0);
        check({tag, "_rdata"},  rsp.r.rdata,      32'h0);
        check({tag, "_rid"},    32'(rsp.r.rid),   32'h0);
    endtask

    // Record model: pulse i is (i+1) cycles high, 3 low; first record has no period.
    function automatic logic [31:0] rec(input int i);
        logic [15:0] p;
        p = (i == 0) ? 16'h0 : 16'(i + 3);
        return {p, 16'(i + 1)};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (req.req) check("gnt", 32'(rsp.gnt), 32'h1);
        if (rsp.rvalid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got rvalid 1 expected no response");
            end else begin
                e = sb.pop_front();
                check(e.name, rsp.r.rdata, e.rdata);
                check({e.name, "_rid"}, 32'(rsp.r.rid), 32'(e.rid));
            end
        end
    end

    initial begin
        rv.push_back('{1'b0, 8'h00, 32'h0,        32'h0,        "rst_ctrl"});
        rv.push_back('{1'b0, 8'h04, 32'h0,        32'h1,        "rst_status"});
        rv.push_back('{1'b0, 8'h08, 32'h0,        32'h0,        "rst_data_empty"});
        rv.push_back('{1'b0, 8'h0C, 32'h0,        32'h0,        "rst_pcount"});
        rv.push_back('{1'b0, 8'h20, 32'h0,        32'hDEADBEEF, "rst_unmapped_rd"});
        rv.push_back('{1'b1, 8'h10, 32'hFFFFFFFF, 32'h0,        "wr_unmapped"});
        rv.push_back('{1'b1, 8'h04, 32'h3,        32'h0,        "wr_status_ro"});
        rv.push_back('{1'b0, 8'h04, 32'h0,        32'h1,        "status_after_ro_wr"});
        rv.push_back('{1'b0, 8'h00, 32'h0,        32'h0,        "ctrl_after_junk"});

        req   = '0;
        pulse = 1'b0;
        rst   = 1'b1;
        repeat (3) tick();
        reset_outputs("in_reset");
        rst = 1'b0;
        tick();
        apply_table();

        // Two pulses: high 3 / low 5 / high 3.
        bus(1'b1, 8'h00, 32'h1, 32'h0, "en");
        tick();
        bus(1'b0, 8'h00, 32'h0, 32'h1, "ctrl_en");
        pulse_n(3, 5);
        pulse_n(3, 4);
        bus(1'b0, 8'h04, 32'h0, 32'h20, "two_status");
        bus(1'b0, 8'h08, 32'h0, 32'h00000003, "two_rec0");
        tick();
        check("two_irq_mid", 32'(irq), 32'h1);
        bus(1'b0, 8'h08, 32'h0, 32'h00080003, "two_rec1");
        tick();
        check("two_irq_end", 32'(irq), 32'h0);
        bus(1'b0, 8'h0C, 32'h0, 32'h2, "two_pcount");
        bus(1'b0, 8'h04, 32'h0, 32'h1, "two_status_end");

        // Five pulses into a depth-4 FIFO: overflow.
        bus(1'b1, 8'h00, 32'h3, 32'h0, "clr0");
        tick();
        for (int i = 0; i < 5; i++) pulse_n(i + 1, 3);
        bus(1'b0, 8'h04, 32'h0, 32'h46, "ovf_status");
        bus(1'b0, 8'h0C, 32'h0, 32'h5, "ovf_pcount");
        check("ovf_irq", 32'(irq), 32'h1);
        for (int i = 0; i < 4; i++) bus(1'b0, 8'h08, 32'h0, rec(i), $sformatf("ovf_rec%0d", i));
        bus(1'b0, 8'h04, 32'h0, 32'h05, "ovf_status_drained");
        bus(1'b1, 8'h04, 32'h4, 32'h0, "ovf_clr");
        bus(1'b0, 8'h04, 32'h0, 32'h01, "ovf_status_cleared");

        // Full FIFO, pop coincident with the fifth falling edge.
        bus(1'b1, 8'h00, 32'h3, 32'h0, "clr1");
        tick();
        for (int i = 0; i < 4; i++) pulse_n(i + 1, 3);
        pulse = 1'b1;
        repeat (4) tick();
        bus_issue(1'b0, 8'h08, 32'h0, rec(0), "pp_rec0");
        tick();
        pulse = 1'b0;
        bus_idle();
        repeat (3) tick();
        bus(1'b0, 8'h04, 32'h0, 32'h42, "pp_status");
        bus(1'b0, 8'h0C, 32'h0, 32'h5, "pp_pcount");
        for (int i = 1; i < 5; i++) bus(1'b0, 8'h08, 32'h0, rec(i), $sformatf("pp_rec%0d", i));
        bus(1'b0, 8'h04, 32'h0, 32'h01, "pp_status_end");

        // Disable retains FIFO; enabling while high gives no record.
        bus(1'b1, 8'h00, 32'h3, 32'h0, "clr2");
        tick();
        pulse_n(2, 3);
        bus(1'b1, 8'h00, 32'h0, 32'h0, "dis");
        tick();
        pulse = 1'b1;
        repeat (2) tick();
        bus(1'b1, 8'h00, 32'h1, 32'h0, "en_high");
        repeat (3) tick();
        pulse = 1'b0;
        repeat (3) tick();
        bus(1'b0, 8'h04, 32'h0, 32'h10, "dis_status");
        bus(1'b0, 8'h0C, 32'h0, 32'h1, "dis_pcount");
        pulse_n(2, 3);
        bus(1'b0, 8'h08, 32'h0, 32'h00000002, "dis_rec0");
        bus(1'b0, 8'h08, 32'h0, 32'h00000002, "dis_rec1_noprev");
        bus(1'b0, 8'h04, 32'h0, 32'h01, "dis_status_end");

        // Clear coincident with a falling edge.
        bus(1'b1, 8'h00, 32'h3, 32'h0, "clr3");
        tick();
        pulse_n(2, 3);
        pulse = 1'b1;
        repeat (2) tick();
        bus_issue(1'b1, 8'h00, 32'h3, 32'h0, "clr_on_fall");
        tick();
        pulse = 1'b0;
        bus_idle();
        repeat (3) tick();
        bus(1'b0, 8'h04, 32'h0, 32'h01, "cf_status");
        bus(1'b0, 8'h0C, 32'h0, 32'h0, "cf_pcount");
        bus(1'b0, 8'h00, 32'h0, 32'h1, "cf_ctrl");
        bus(1'b0, 8'h08, 32'h0, 32'h0, "cf_data_empty");

        // Saturation of both counters.
        bus(1'b1, 8'h00, 32'h3, 32'h0, "clr4");
        tick();
        pulse_n(65600, 3);
        pulse_n(1, 3);
        bus(1'b0, 8'h08, 32'h0, 32'h0000FFFF, "sat_high");
        bus(1'b0, 8'h08, 32'h0, 32'hFFFF0001, "sat_period");

        // Reset mid-pulse with two records stored.
        bus(1'b1, 8'h00, 32'h3, 32'h0, "clr5");
        tick();
        pulse_n(2, 3);
        pulse_n(2, 3);
        pulse = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        reset_outputs("mid_reset");
        tick();
        rst = 1'b0;
        pulse = 1'b0;
        repeat (2) tick();
        check("post_reset_irq", 32'(irq), 32'h0);
        apply_table();

        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
